// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit decode/imem/redirect signal bundle
interface fetch_unit_if;
  logic        stall;
  logic        jb;
  logic [31:0] jb_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_valid;
  logic        fetch_busy;

  modport master (
    input  stall, jb, jb_target, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, pc, inst, inst_valid, fetch_busy
  );

  modport slave (
    output stall, jb, jb_target, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, pc, inst, inst_valid, fetch_busy
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end with single outstanding read
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] NOP      = 32'h00000013
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {ISSUE, WAIT, HOLD, DISCARD} state_t;

  state_t      state, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ISSUE;
      pc_q     <= RESET_PC;
      pc_out_q <= 32'h0;
      inst_q   <= NOP;
      valid_q  <= 1'b0;
    end else begin
      state    <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      inst_q   <= inst_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    inst_d   = inst_q;
    valid_d  = valid_q;
    case (state)
      ISSUE: begin
        // a redirect here leaves the request just issued stale
        if (bus.jb) begin
          pc_d    = bus.jb_target;
          state_d = DISCARD;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.jb) begin
          pc_d    = bus.jb_target;
          state_d = bus.imem_rvalid ? ISSUE : DISCARD;
        end else if (bus.imem_rvalid) begin
          inst_d   = bus.imem_rdata;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          pc_d     = pc_q + 32'd4;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (bus.jb) begin
          valid_d = 1'b0;
          pc_d    = bus.jb_target;
          state_d = ISSUE;
        end else if (!bus.stall) begin
          valid_d = 1'b0;
          state_d = WAIT;
        end
      end
      DISCARD: begin
        if (bus.jb) pc_d = bus.jb_target;
        if (bus.imem_rvalid) state_d = ISSUE;
      end
      default: state_d = ISSUE;
    endcase
  end

  // consuming in HOLD issues the next fetch in the same cycle
  assign bus.imem_req   = (state == ISSUE) || (state == HOLD && !bus.stall && !bus.jb);
  assign bus.imem_addr  = pc_q;
  assign bus.pc         = pc_out_q;
  assign bus.inst       = valid_q ? inst_q : NOP;
  assign bus.inst_valid = valid_q;
  assign bus.fetch_busy = !valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed table, reset sequences and randomized model check for fetch_unit
module tb_fetch_unit;
  localparam logic [31:0] NOPW = 32'h00000013;
  localparam logic [31:0] K    = 32'hA5A5A5A5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if bus ();
  fetch_unit dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        stall;
    logic        jb;
    logic [31:0] tgt;
    logic        rv;
    logic [31:0] rd;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] inst;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int          ready;
  } mem_t;

  vec_t tbl[27];
  mem_t mem_q[$];

  function automatic vec_t mk(logic s, logic j, logic [31:0] t, logic r, logic [31:0] d,
                              logic q, logic [31:0] a, logic v, logic [31:0] p, logic [31:0] i);
    vec_t x;
    x.stall = s; x.jb = j; x.tgt = t; x.rv = r; x.rd = d;
    x.req = q; x.addr = a; x.vld = v; x.pc = p; x.inst = v ? i : NOPW;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic req, input logic [31:0] addr,
                            input logic vld, input logic [31:0] pc, input logic [31:0] inst);
    chk({tag, " req"}, {31'b0, bus.imem_req}, {31'b0, req});
    chk({tag, " addr"}, bus.imem_addr, addr);
    chk({tag, " valid"}, {31'b0, bus.inst_valid}, {31'b0, vld});
    chk({tag, " busy"}, {31'b0, bus.fetch_busy}, {31'b0, !vld});
    chk({tag, " pc"}, bus.pc, pc);
    chk({tag, " inst"}, bus.inst, inst);
  endtask

  task automatic drive(input logic s, input logic j, input logic [31:0] t,
                       input logic r, input logic [31:0] d);
    bus.stall = s; bus.jb = j; bus.jb_target = t; bus.imem_rvalid = r; bus.imem_rdata = d;
  endtask

  // behavioural model state
  logic        m_out, m_stale, m_valid;
  logic [31:0] m_fetch, m_pc_out, m_inst;

  initial begin
    logic        r_stall, r_jb, r_rv, m_req, n_out, n_stale, n_valid, seen_req;
    logic [31:0] r_tgt, r_rd, n_fetch, n_pc_out, n_inst, seen_addr;

    tbl[0]  = mk(0,0,0,0,0,            1,32'h0,0,32'h0,0);
    tbl[1]  = mk(0,0,0,1,K,            0,32'h0,0,32'h0,0);
    tbl[2]  = mk(0,0,0,0,0,            1,32'h4,1,32'h0,K);
    tbl[3]  = mk(0,0,0,1,32'hA5A5A5A1, 0,32'h4,0,32'h0,0);
    tbl[4]  = mk(1,0,0,0,0,            0,32'h8,1,32'h4,32'hA5A5A5A1);
    tbl[5]  = mk(1,0,0,0,0,            0,32'h8,1,32'h4,32'hA5A5A5A1);
    tbl[6]  = mk(1,0,0,0,0,            0,32'h8,1,32'h4,32'hA5A5A5A1);
    tbl[7]  = mk(0,0,0,0,0,            1,32'h8,1,32'h4,32'hA5A5A5A1);
    tbl[8]  = mk(0,0,0,1,32'hA5A5A5AD, 0,32'h8,0,32'h4,0);
    tbl[9]  = mk(0,1,32'h100,0,0,      0,32'hC,1,32'h8,32'hA5A5A5AD);
    tbl[10] = mk(0,0,0,0,0,            1,32'h100,0,32'h8,0);
    tbl[11] = mk(0,1,32'h200,0,0,      0,32'h100,0,32'h8,0);
    tbl[12] = mk(0,0,0,0,0,            0,32'h200,0,32'h8,0);
    tbl[13] = mk(0,0,0,1,32'hDEADBEEF, 0,32'h200,0,32'h8,0);
    tbl[14] = mk(0,0,0,0,0,            1,32'h200,0,32'h8,0);
    tbl[15] = mk(0,0,0,1,32'hA5A5A7A5, 0,32'h200,0,32'h8,0);
    tbl[16] = mk(1,1,32'h300,0,0,      0,32'h204,1,32'h200,32'hA5A5A7A5);
    tbl[17] = mk(0,0,0,0,0,            1,32'h300,0,32'h200,0);
    tbl[18] = mk(0,1,32'h400,1,32'h12345678, 0,32'h300,0,32'h200,0);
    tbl[19] = mk(0,0,0,0,0,            1,32'h400,0,32'h200,0);
    tbl[20] = mk(0,0,0,1,32'hA5A5A1A5, 0,32'h400,0,32'h200,0);
    tbl[21] = mk(1,0,0,1,32'hBAD0BAD0, 0,32'h404,1,32'h400,32'hA5A5A1A5);
    tbl[22] = mk(0,1,32'hFFFFFFFC,0,0, 0,32'h404,1,32'h400,32'hA5A5A1A5);
    tbl[23] = mk(0,0,0,1,32'hBAD1BAD1, 1,32'hFFFFFFFC,0,32'h400,0);
    tbl[24] = mk(0,0,0,1,32'h5A5A5A59, 0,32'hFFFFFFFC,0,32'h400,0);
    tbl[25] = mk(0,0,0,0,0,            1,32'h0,1,32'hFFFFFFFC,32'h5A5A5A59);
    tbl[26] = mk(0,0,0,0,0,            0,32'h0,0,32'hFFFFFFFC,0);

    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    chk("reset valid", {31'b0, bus.inst_valid}, 32'h0);
    chk("reset busy", {31'b0, bus.fetch_busy}, 32'h1);
    chk("reset inst", bus.inst, NOPW);
    chk("reset pc", bus.pc, 32'h0);
    chk("reset addr", bus.imem_addr, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 27; i++) begin
      drive(tbl[i].stall, tbl[i].jb, tbl[i].tgt, tbl[i].rv, tbl[i].rd);
      #1;
      check_outs($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].vld, tbl[i].pc, tbl[i].inst);
      @(posedge clk);
      #1;
    end

    // asynchronous reset while a read is outstanding
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    check_outs("rst_mid", 1'b1, 32'h0, 1'b0, 32'h0, NOPW);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_outs("rst_rel", 1'b1, 32'h0, 1'b0, 32'h0, NOPW);

    // jb in ISSUE leaves a stale request that must drain
    bus.jb = 1'b1; bus.jb_target = 32'h0000ABC1;
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    #1;
    check_outs("issue_jb", 1'b0, 32'h0000ABC1, 1'b0, 32'h0, NOPW);
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0BADF00D;
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    #1;
    check_outs("issue_jb_drain", 1'b1, 32'h0000ABC1, 1'b0, 32'h0, NOPW);

    // randomized run against the behavioural model with a 1..3 cycle memory
    rst = 1'b1;
    #2;
    rst = 1'b0;
    mem_q.delete();
    m_out = 0; m_stale = 0; m_valid = 0; m_fetch = 32'h0; m_pc_out = 32'h0; m_inst = NOPW;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r_stall = ($urandom % 3) == 0;
      r_jb    = ($urandom % 9) == 0;
      r_tgt   = (($urandom % 4) == 0) ? $urandom : ($urandom & 32'h00000FFC);
      if (mem_q.size() > 0 && mem_q[0].ready <= cyc) begin
        r_rv = 1'b1;
        r_rd = mem_q[0].addr ^ K;
      end else begin
        r_rv = ($urandom % 16) == 0;
        r_rd = $urandom;
      end
      drive(r_stall, r_jb, r_tgt, r_rv, r_rd);
      m_req = !m_out && (!m_valid || (!r_stall && !r_jb));
      #1;
      check_outs($sformatf("rnd%0d", cyc), m_req, m_fetch, m_valid, m_pc_out,
                 m_valid ? m_inst : NOPW);
      seen_req  = bus.imem_req;
      seen_addr = bus.imem_addr;
      @(posedge clk);
      if (r_rv && mem_q.size() > 0 && mem_q[0].ready <= cyc) void'(mem_q.pop_front());
      if (seen_req) mem_q.push_back('{addr: seen_addr, ready: cyc + int'($urandom_range(1, 3))});

      n_out = m_out; n_stale = m_stale; n_valid = m_valid;
      n_fetch = m_fetch; n_pc_out = m_pc_out; n_inst = m_inst;
      if (m_out && r_rv) begin
        n_out = 0;
        n_stale = 0;
        if (!(m_stale || r_jb)) begin
          n_valid = 1; n_pc_out = m_fetch; n_inst = r_rd; n_fetch = m_fetch + 32'd4;
        end
      end else if (m_out && r_jb) begin
        n_stale = 1;
      end
      if (m_req) begin
        n_out = 1;
        n_stale = r_jb;
      end
      if (m_valid && (r_jb || !r_stall)) n_valid = 0;
      if (r_jb) n_fetch = r_tgt;
      m_out = n_out; m_stale = n_stale; m_valid = n_valid;
      m_fetch = n_fetch; m_pc_out = n_pc_out; m_inst = n_inst;
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
